// File: rtl/alu_mem_regfile_pkg.sv
// Shared widths and ALU opcode names for the ALU / data-memory / register-file slice.
package alu_mem_regfile_pkg;

    localparam int unsigned DATA_W    = 16;
    localparam int unsigned REG_AW    = 3;
    localparam int unsigned MEM_AW    = 3;
    localparam int unsigned REG_COUNT = 8;
    localparam int unsigned MEM_DEPTH = 8;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_NOT = 3'b010,
        ALU_SHL = 3'b011,
        ALU_SHR = 3'b100,
        ALU_AND = 3'b101,
        ALU_OR  = 3'b110,
        ALU_SLT = 3'b111
    } alu_op_e;

endpackage

// File: rtl/alu_mem_regfile_gpr.sv
// General-purpose register file: two combinational read ports, one synchronous write port.
module alu_mem_regfile_gpr #(
    parameter int unsigned DATA_W    = alu_mem_regfile_pkg::DATA_W,
    parameter int unsigned REG_COUNT = alu_mem_regfile_pkg::REG_COUNT
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   we_i,
    input  logic [alu_mem_regfile_pkg::REG_AW-1:0] waddr_i,
    input  logic [DATA_W-1:0]                      wdata_i,
    input  logic [alu_mem_regfile_pkg::REG_AW-1:0] raddr1_i,
    input  logic [alu_mem_regfile_pkg::REG_AW-1:0] raddr2_i,
    output logic [DATA_W-1:0]                      rdata1_o,
    output logic [DATA_W-1:0]                      rdata2_o
);

    logic [DATA_W-1:0] regs_q [REG_COUNT];

    // Reads come straight from storage; a same-cycle write only shows after the edge.
    assign rdata1_o = regs_q[raddr1_i];
    assign rdata2_o = regs_q[raddr2_i];

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < REG_COUNT; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

endmodule

// File: rtl/alu_mem_regfile.sv
// Single-cycle datapath slice: GPR file, operand mux, ALU, data memory and writeback mux.
module alu_mem_regfile #(
    parameter int unsigned DATA_W    = alu_mem_regfile_pkg::DATA_W,
    parameter int unsigned REG_COUNT = alu_mem_regfile_pkg::REG_COUNT,
    parameter int unsigned MEM_DEPTH = alu_mem_regfile_pkg::MEM_DEPTH
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   reg_write_en,
    input  logic [alu_mem_regfile_pkg::REG_AW-1:0] reg_write_dest,
    input  logic [alu_mem_regfile_pkg::REG_AW-1:0] reg_read_addr_1,
    input  logic [alu_mem_regfile_pkg::REG_AW-1:0] reg_read_addr_2,
    input  logic [DATA_W-1:0]                      imm,
    input  logic                                   alu_src,
    input  logic [2:0]                             alu_control,
    input  logic                                   mem_write,
    input  logic                                   mem_read,
    input  logic                                   mem_to_reg,
    output logic [DATA_W-1:0]                      reg_read_data_1,
    output logic [DATA_W-1:0]                      reg_read_data_2,
    output logic [DATA_W-1:0]                      alu_result,
    output logic                                   zero,
    output logic [DATA_W-1:0]                      mem_read_data
);

    import alu_mem_regfile_pkg::*;

    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] wb_data;
    logic [MEM_AW-1:0] mem_addr;
    logic [DATA_W-1:0] mem_q [MEM_DEPTH];
    alu_op_e           alu_op;

    alu_mem_regfile_gpr #(
        .DATA_W    (DATA_W),
        .REG_COUNT (REG_COUNT)
    ) u_gpr (
        .clk      (clk),
        .reset    (reset),
        .we_i     (reg_write_en),
        .waddr_i  (reg_write_dest),
        .wdata_i  (wb_data),
        .raddr1_i (reg_read_addr_1),
        .raddr2_i (reg_read_addr_2),
        .rdata1_o (reg_read_data_1),
        .rdata2_o (reg_read_data_2)
    );

    assign op_a   = reg_read_data_1;
    assign op_b   = alu_src ? imm : reg_read_data_2;
    assign alu_op = alu_op_e'(alu_control);

    always_comb begin
        alu_result = '0;
        case (alu_op)
            ALU_ADD: alu_result = op_a + op_b;
            ALU_SUB: alu_result = op_a - op_b;
            ALU_NOT: alu_result = ~op_a;
            // Shift distances of a full word or more flush the result to zero.
            ALU_SHL: alu_result = (32'(op_b) >= DATA_W) ? '0 : (op_a << op_b);
            ALU_SHR: alu_result = (32'(op_b) >= DATA_W) ? '0 : (op_a >> op_b);
            ALU_AND: alu_result = op_a & op_b;
            ALU_OR:  alu_result = op_a | op_b;
            ALU_SLT: alu_result = {{(DATA_W-1){1'b0}}, (op_a < op_b)};
            default: alu_result = '0;
        endcase
    end

    assign zero = (alu_result == '0);

    // Only the low address bits select a word, so larger addresses alias.
    assign mem_addr      = alu_result[MEM_AW-1:0];
    assign mem_read_data = mem_read ? mem_q[mem_addr] : '0;
    assign wb_data       = mem_to_reg ? mem_read_data : alu_result;

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < MEM_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_write) begin
            mem_q[mem_addr] <= reg_read_data_2;
        end
    end

endmodule

// File: tb/tb_alu_mem_regfile.sv
// Self-checking bench for alu_mem_regfile: directed scenarios plus randomized traffic against an array model.
module tb_alu_mem_regfile;

    logic        clk;
    logic        reset;
    logic        reg_write_en;
    logic [2:0]  reg_write_dest;
    logic [2:0]  reg_read_addr_1;
    logic [2:0]  reg_read_addr_2;
    logic [15:0] imm;
    logic        alu_src;
    logic [2:0]  alu_control;
    logic        mem_write;
    logic        mem_read;
    logic        mem_to_reg;
    logic [15:0] reg_read_data_1;
    logic [15:0] reg_read_data_2;
    logic [15:0] alu_result;
    logic        zero;
    logic [15:0] mem_read_data;

    int unsigned n_checks;
    int unsigned n_errors;

    int unsigned m_regs [8];
    int unsigned m_mem  [8];

    alu_mem_regfile #(
        .DATA_W    (16),
        .REG_COUNT (8),
        .MEM_DEPTH (8)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .reg_write_en    (reg_write_en),
        .reg_write_dest  (reg_write_dest),
        .reg_read_addr_1 (reg_read_addr_1),
        .reg_read_addr_2 (reg_read_addr_2),
        .imm             (imm),
        .alu_src         (alu_src),
        .alu_control     (alu_control),
        .mem_write       (mem_write),
        .mem_read        (mem_read),
        .mem_to_reg      (mem_to_reg),
        .reg_read_data_1 (reg_read_data_1),
        .reg_read_data_2 (reg_read_data_2),
        .alu_result      (alu_result),
        .zero            (zero),
        .mem_read_data   (mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int unsigned ref_alu(input int unsigned op, input int unsigned a, input int unsigned b);
        case (op)
            0: return (a + b) % 65536;
            1: return (a + 65536 - b) % 65536;
            2: return 65535 - a;
            3: return (b >= 16) ? 0 : (a * (1 << b)) % 65536;
            4: return (b >= 16) ? 0 : a / (1 << b);
            5: return a & b;
            6: return a | b;
            default: return (a < b) ? 1 : 0;
        endcase
    endfunction

    function automatic int unsigned exp_alu();
        int unsigned b;
        b = alu_src ? int'(imm) : m_regs[reg_read_addr_2];
        return ref_alu(alu_control, m_regs[reg_read_addr_1], b);
    endfunction

    function automatic int unsigned exp_mem_rd();
        return mem_read ? m_mem[exp_alu() % 8] : 0;
    endfunction

    task automatic set_idle();
        reset = 1'b1; reg_write_en = 1'b0; reg_write_dest = '0;
        reg_read_addr_1 = '0; reg_read_addr_2 = '0; imm = '0; alu_src = 1'b0;
        alu_control = '0; mem_write = 1'b0; mem_read = 1'b0; mem_to_reg = 1'b0;
    endtask

    // Compare every combinational output to the model while inputs are stable.
    task automatic settle_and_check();
        int unsigned res;
        #1;
        res = exp_alu();
        check_val("rd1", reg_read_data_1, m_regs[reg_read_addr_1]);
        check_val("rd2", reg_read_data_2, m_regs[reg_read_addr_2]);
        check_val("alu", alu_result, res);
        check_val("zero", zero, (res == 0) ? 1 : 0);
        check_val("memrd", mem_read_data, exp_mem_rd());
    endtask

    task automatic commit();
        int unsigned res, wb, st;
        res = exp_alu();
        wb  = mem_to_reg ? exp_mem_rd() : res;
        st  = m_regs[reg_read_addr_2];
        @(posedge clk);
        if (!reset) begin
            for (int i = 0; i < 8; i++) begin
                m_regs[i] = 0;
                m_mem[i]  = 0;
            end
        end else begin
            if (reg_write_en) m_regs[reg_write_dest] = wb;
            if (mem_write)    m_mem[res % 8] = st;
        end
        @(negedge clk);
    endtask

    task automatic write_reg(input int unsigned r, input int unsigned v);
        set_idle();
        alu_src = 1'b1; imm = 16'(v); alu_control = 3'b000;
        reg_write_en = 1'b1; reg_write_dest = 3'(r);
        settle_and_check();
        commit();
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < 8; i++) begin
            set_idle();
            reg_read_addr_1 = 3'(i); reg_read_addr_2 = 3'(7 - i);
            alu_src = 1'b1; imm = 16'(i); mem_read = 1'b1;
            settle_and_check();
            check_val({tag, "_reg"}, reg_read_data_1, 0);
            check_val({tag, "_mem"}, mem_read_data, 0);
            commit();
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        set_idle();
        reset = 1'b0;
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            m_regs[i] = 0;
            m_mem[i]  = 0;
        end

        check_all_zero("reset");

        write_reg(1, 5);
        write_reg(2, 3);
        set_idle();
        reg_read_addr_1 = 3'd1; reg_read_addr_2 = 3'd2; alu_control = 3'b001;
        settle_and_check();
        check_val("sub_r1_r2", alu_result, 16'h0002);
        check_val("sub_zero0", zero, 0);
        commit();
        set_idle();
        reg_read_addr_1 = 3'd1; reg_read_addr_2 = 3'd1; alu_control = 3'b001;
        settle_and_check();
        check_val("sub_zero1", zero, 1);
        commit();

        write_reg(1, 16'hFFFF);
        write_reg(2, 1);
        set_idle();
        reg_read_addr_1 = 3'd1; reg_read_addr_2 = 3'd2; alu_control = 3'b000;
        settle_and_check();
        check_val("add_wrap", alu_result, 16'h0000);
        check_val("add_wrap_z", zero, 1);
        alu_control = 3'b111; reg_read_addr_1 = 3'd2; reg_read_addr_2 = 3'd1;
        settle_and_check();
        check_val("slt", alu_result, 1);
        alu_control = 3'b010;
        settle_and_check();
        check_val("not", alu_result, 16'hFFFE);
        alu_control = 3'b011; alu_src = 1'b1; imm = 16'd17;
        settle_and_check();
        check_val("shl_big", alu_result, 16'h0000);
        commit();

        write_reg(1, 16'h1234);
        set_idle();
        reg_read_addr_1 = 3'd0; reg_read_addr_2 = 3'd1; alu_src = 1'b1; imm = 16'd10; mem_write = 1'b1;
        settle_and_check();
        commit();
        set_idle();
        alu_src = 1'b1; imm = 16'd2; mem_read = 1'b1; mem_to_reg = 1'b1;
        reg_write_en = 1'b1; reg_write_dest = 3'd3;
        settle_and_check();
        check_val("load_alias", mem_read_data, 16'h1234);
        commit();
        set_idle();
        reg_read_addr_1 = 3'd3; alu_src = 1'b1; imm = 16'd2;
        settle_and_check();
        check_val("r3_loaded", reg_read_data_1, 16'h1234);
        check_val("memrd_off", mem_read_data, 0);
        commit();

        write_reg(4, 16'h0111);
        set_idle();
        alu_src = 1'b1; imm = 16'h55AA; reg_write_en = 1'b1; reg_write_dest = 3'd4; reg_read_addr_2 = 3'd4;
        settle_and_check();
        check_val("r4_old", reg_read_data_2, 16'h0111);
        commit();
        set_idle();
        reg_read_addr_2 = 3'd4;
        settle_and_check();
        check_val("r4_new", reg_read_data_2, 16'h55AA);
        commit();

        set_idle();
        reset = 1'b0; reg_write_en = 1'b1; reg_write_dest = 3'd5; alu_src = 1'b1; imm = 16'h0003;
        mem_write = 1'b1; reg_read_addr_2 = 3'd4;
        settle_and_check();
        commit();
        check_all_zero("rst_wr");

        for (int n = 0; n < 400; n++) begin
            reset           = ($urandom_range(0, 39) != 0);
            reg_write_en    = 1'($urandom);
            reg_write_dest  = 3'($urandom);
            reg_read_addr_1 = 3'($urandom);
            reg_read_addr_2 = 3'($urandom);
            case ($urandom_range(0, 3))
                0:       imm = 16'($urandom_range(0, 20));
                1:       imm = 16'hFFFF;
                default: imm = 16'($urandom);
            endcase
            alu_src     = 1'($urandom);
            alu_control = 3'($urandom);
            mem_write   = 1'($urandom);
            mem_read    = 1'($urandom);
            mem_to_reg  = 1'($urandom);
            settle_and_check();
            commit();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
